// File: rtl/fetch_pc_gen_if.sv
// Instruction-memory fetch request channel.
//   req_valid      : fetch request valid (master -> slave)
//   req_pc         : fetch address (master -> slave)
//   req_pred_taken : request target came from a BTB prediction (master -> slave)
//   req_ready      : memory accepts the request (slave -> master)
interface fetch_pc_gen_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic                  req_pred_taken;
    logic                  req_ready;

    modport master (
        output req_valid,
        output req_pc,
        output req_pred_taken,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_pc,
        input  req_pred_taken,
        output req_ready
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// Next-PC generator for the fetch stage. Holds the fetch PC, issues imem requests and
// drives npc as the BTB lookup address.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   redirect_valid  : controller redirect (mispredict/trap) this cycle
//   redirect_pc     : redirect target
//   btb_hit         : BTB hit for the current req_pc
//   btb_pred_pc     : BTB predicted target for req_pc
//   stall           : downstream stall, blocks PC advance
//   imem            : fetch request channel (req_valid/req_pc/req_pred_taken/req_ready)
//   npc             : value the PC register takes at the next posedge
module fetch_pc_gen #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned            INSN_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  btb_hit,
    input  logic [ADDR_WIDTH-1:0] btb_pred_pc,
    input  logic                  stall,
    fetch_pc_gen_if.master        imem,
    output logic [ADDR_WIDTH-1:0] npc
);

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] PEND = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(INSN_BYTES);

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pend_pc;
    logic [ADDR_WIDTH-1:0] pend_pc_next;
    logic                  req_valid;
    logic                  pred_taken;
    logic                  pred_taken_next;
    logic                  adv;

    assign adv = req_valid & imem.req_ready & ~stall;

    assign imem.req_valid      = req_valid;
    assign imem.req_pc         = pc;
    assign imem.req_pred_taken = pred_taken;

    // State, PC and registered request outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            pend_pc    <= '0;
            req_valid  <= 1'b0;
            pred_taken <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= npc;
            pend_pc    <= pend_pc_next;
            req_valid  <= (state_next != BOOT);
            pred_taken <= pred_taken_next;
        end
    end

    // Next-state and next-PC selection.
    always_comb begin
        state_next      = state;
        npc             = pc;
        pend_pc_next    = pend_pc;
        pred_taken_next = pred_taken;

        if (rst) begin
            state_next      = BOOT;
            npc             = RESET_PC;
            pend_pc_next    = '0;
            pred_taken_next = 1'b0;
        end else begin
            case (state)
                BOOT:    state_next = RUN;
                RUN:     if (redirect_valid && stall && !adv) state_next = PEND;
                PEND:    if (!redirect_valid && adv) state_next = RUN;
                default: state_next = BOOT;
            endcase

            // A redirect flushes the outstanding request, so it ignores the hold rule.
            if (redirect_valid) begin
                npc             = redirect_pc;
                pred_taken_next = 1'b0;
                if (state_next == PEND) pend_pc_next = redirect_pc;
            end else if (state == PEND) begin
                // The redirect target is fetched unpredicted; the BTB is not consulted.
                if (adv) begin
                    npc             = pend_pc + INC;
                    pred_taken_next = 1'b0;
                end
            end else if (adv && btb_hit) begin
                npc             = btb_pred_pc;
                pred_taken_next = 1'b1;
            end else if (adv) begin
                npc             = pc + INC;
                pred_taken_next = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: per-cycle vector table plus a few hand sequences.
module tb_fetch_pc_gen;

    localparam int unsigned AW = 32;
    localparam logic [AW-1:0] RST_PC = 32'h100;

    logic          clk;
    logic          rst;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          btb_hit;
    logic [AW-1:0] btb_pred_pc;
    logic          stall;
    logic [AW-1:0] npc;

    fetch_pc_gen_if #(.ADDR_WIDTH(AW)) imem ();

    fetch_pc_gen #(
        .ADDR_WIDTH(AW),
        .RESET_PC  (RST_PC),
        .INSN_BYTES(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .btb_hit       (btb_hit),
        .btb_pred_pc   (btb_pred_pc),
        .stall         (stall),
        .imem          (imem.master),
        .npc           (npc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          rst;
        logic          rv;
        logic [AW-1:0] rpc;
        logic          bh;
        logic [AW-1:0] bpc;
        logic          stall;
        logic          rdy;
        logic [AW-1:0] e_npc;    // npc during this cycle
        logic          e_valid;  // after the edge
        logic [AW-1:0] e_pc;
        logic          e_pred;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic r, logic rv, logic [AW-1:0] rpc, logic bh,
                                logic [AW-1:0] bpc, logic st, logic rdy,
                                logic [AW-1:0] e_npc, logic e_valid,
                                logic [AW-1:0] e_pc, logic e_pred);
        vec_t v;
        v.rst = r; v.rv = rv; v.rpc = rpc; v.bh = bh; v.bpc = bpc;
        v.stall = st; v.rdy = rdy; v.e_npc = e_npc; v.e_valid = e_valid;
        v.e_pc = e_pc; v.e_pred = e_pred;
        return v;
    endfunction

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst            = v.rst;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        btb_hit        = v.bh;
        btb_pred_pc    = v.bpc;
        stall          = v.stall;
        imem.req_ready = v.rdy;
    endtask

    // Inputs are changed 1 time unit after posedge; npc is checked before the next edge,
    // registered outputs 1 time unit after it.
    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        drive(v);
        #1;
        tag = $sformatf("v%0d npc", idx);
        chk(tag, npc, v.e_npc);
        @(posedge clk);
        #1;
        tag = $sformatf("v%0d req_valid", idx);
        chk(tag, AW'(imem.req_valid), AW'(v.e_valid));
        tag = $sformatf("v%0d req_pc", idx);
        chk(tag, imem.req_pc, v.e_pc);
        tag = $sformatf("v%0d pred_taken", idx);
        chk(tag, AW'(imem.req_pred_taken), AW'(v.e_pred));
    endtask

    initial begin
        //           rst rv rpc            bh bpc           st rdy  e_npc         ev e_pc          ep
        // reset, boot, sequential
        vecs.push_back(mk(1, 0, 0,             0, 0,            0, 1, 32'h100,      0, 32'h100,      0));
        vecs.push_back(mk(0, 0, 0,             0, 0,            0, 1, 32'h100,      1, 32'h100,      0));
        vecs.push_back(mk(0, 0, 0,             0, 0,            0, 1, 32'h104,      1, 32'h104,      0));
        vecs.push_back(mk(0, 0, 0,             0, 0,            0, 1, 32'h108,      1, 32'h108,      0));
        // BTB hit and the following sequential fetch
        vecs.push_back(mk(0, 1, 32'h200,       0, 0,            0, 1, 32'h200,      1, 32'h200,      0));
        vecs.push_back(mk(0, 0, 0,             1, 32'h400,      0, 1, 32'h400,      1, 32'h400,      1));
        vecs.push_back(mk(0, 0, 0,             0, 0,            0, 1, 32'h404,      1, 32'h404,      0));
        // ready low for three cycles (hit ignored while not advancing)
        vecs.push_back(mk(0, 1, 32'h300,       0, 0,            0, 1, 32'h300,      1, 32'h300,      0));
        vecs.push_back(mk(0, 0, 0,             0, 0,            0, 0, 32'h300,      1, 32'h300,      0));
        vecs.push_back(mk(0, 0, 0,             1, 32'h777,      0, 0, 32'h300,      1, 32'h300,      0));
        vecs.push_back(mk(0, 0, 0,             0, 0,            0, 0, 32'h300,      1, 32'h300,      0));
        vecs.push_back(mk(0, 0, 0,             0, 0,            0, 1, 32'h304,      1, 32'h304,      0));
        // pred_taken held across ready-low and stall hold cycles
        vecs.push_back(mk(0, 0, 0,             1, 32'h700,      0, 1, 32'h700,      1, 32'h700,      1));
        vecs.push_back(mk(0, 0, 0,             0, 0,            0, 0, 32'h700,      1, 32'h700,      1));
        vecs.push_back(mk(0, 0, 0,             0, 0,            1, 1, 32'h700,      1, 32'h700,      1));
        vecs.push_back(mk(0, 0, 0,             0, 0,            0, 1, 32'h704,      1, 32'h704,      0));
        // redirect beats BTB hit on an advancing cycle
        vecs.push_back(mk(0, 1, 32'h500,       0, 0,            0, 1, 32'h500,      1, 32'h500,      0));
        vecs.push_back(mk(0, 1, 32'h800,       1, 32'h600,      0, 1, 32'h800,      1, 32'h800,      0));
        // redirect while ready low, no stall: stays in RUN, BTB usable next cycle
        vecs.push_back(mk(0, 1, 32'h880,       0, 0,            0, 0, 32'h880,      1, 32'h880,      0));
        vecs.push_back(mk(0, 0, 0,             1, 32'h1000,     0, 1, 32'h1000,     1, 32'h1000,     1));
        // PEND: entry, hold, sticky overwrite, exit ignoring BTB, then BTB used again
        vecs.push_back(mk(0, 1, 32'h900,       0, 0,            1, 1, 32'h900,      1, 32'h900,      0));
        vecs.push_back(mk(0, 0, 0,             1, 32'h1234,     1, 1, 32'h900,      1, 32'h900,      0));
        vecs.push_back(mk(0, 1, 32'hA00,       0, 0,            1, 1, 32'hA00,      1, 32'hA00,      0));
        vecs.push_back(mk(0, 0, 0,             1, 32'h2000,     0, 1, 32'hA04,      1, 32'hA04,      0));
        vecs.push_back(mk(0, 0, 0,             1, 32'h3000,     0, 1, 32'h3000,     1, 32'h3000,     1));
        // wrap at top of address space
        vecs.push_back(mk(0, 1, 32'hFFFFFFFC,  0, 0,            0, 1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0));
        vecs.push_back(mk(0, 0, 0,             0, 0,            0, 1, 32'h0,        1, 32'h0,        0));
        // reset in the middle of PEND discards the pending redirect
        vecs.push_back(mk(0, 1, 32'h40,        0, 0,            1, 1, 32'h40,       1, 32'h40,       0));
        vecs.push_back(mk(1, 0, 0,             0, 0,            1, 1, 32'h100,      0, 32'h100,      0));
        vecs.push_back(mk(0, 0, 0,             0, 0,            0, 1, 32'h100,      1, 32'h100,      0));
        vecs.push_back(mk(0, 0, 0,             0, 0,            0, 1, 32'h104,      1, 32'h104,      0));
        // reset while ready low
        vecs.push_back(mk(1, 0, 0,             0, 0,            0, 0, 32'h100,      0, 32'h100,      0));
        vecs.push_back(mk(0, 0, 0,             0, 0,            0, 1, 32'h100,      1, 32'h100,      0));
        vecs.push_back(mk(0, 0, 0,             1, 32'h5000,     0, 1, 32'h5000,     1, 32'h5000,     1));

        drive(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Hand sequence: long backpressure keeps the payload stable, then it advances.
        drive(mk(0, 1, 32'hC00, 0, 0, 0, 1, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("seq redirect C00", imem.req_pc, 32'hC00);
        for (int k = 0; k < 5; k++) begin
            drive(mk(0, 0, 0, k[0], 32'hDEAD0, 0, 0, 0, 0, 0, 0));
            @(posedge clk);
            #1;
            chk("seq hold pc", imem.req_pc, 32'hC00);
            chk("seq hold valid", AW'(imem.req_valid), AW'(1'b1));
        end
        drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        #1;
        chk("seq release npc", npc, 32'hC04);
        @(posedge clk);
        #1;
        chk("seq release pc", imem.req_pc, 32'hC04);

        // Hand sequence: long stall in PEND with BTB hits, then exit to target+4.
        drive(mk(0, 1, 32'hE00, 0, 0, 1, 1, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            drive(mk(0, 0, 0, 1, 32'hF000, 1, 1, 0, 0, 0, 0));
            @(posedge clk);
            #1;
            chk("pend hold pc", imem.req_pc, 32'hE00);
            chk("pend hold pred", AW'(imem.req_pred_taken), AW'(1'b0));
        end
        drive(mk(0, 0, 0, 1, 32'hF000, 0, 1, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("pend exit pc", imem.req_pc, 32'hE04);
        chk("pend exit pred", AW'(imem.req_pred_taken), AW'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
